// File: rtl/multisim_server_pkg.sv
// Shared widths and frame layout for the multisim server endpoint.
//   TX frame : {id[15:0], seq[15:0], payload}
//   RX frame : {id[15:0], payload}
package multisim_server_pkg;

    localparam int unsigned ID_W   = 16;
    localparam int unsigned SEQ_W  = 16;
    localparam int unsigned DROP_W = 8;

    // Header prepended to every outgoing payload
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [SEQ_W-1:0] seq;
    } tx_hdr_t;

    localparam int unsigned TX_HDR_W = $bits(tx_hdr_t);
    localparam int unsigned RX_HDR_W = ID_W;

    function automatic tx_hdr_t make_tx_hdr(input logic [ID_W-1:0] id,
                                            input logic [SEQ_W-1:0] seq);
        tx_hdr_t h;
        h.id  = id;
        h.seq = seq;
        return h;
    endfunction

endpackage

// File: rtl/multisim_server_fifo.sv
// Registered-pointer RAM FIFO; no same-cycle bypass, no write-through on full.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_vld/wr_rdy/wr_data  write side (wr_rdy = not full)
//   rd_vld/rd_rdy/rd_data  read side (rd_vld = not empty, rd_data = head)
module multisim_server_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             full, empty, wr_en, rd_en;

    // Extra pointer MSB separates full (MSBs differ) from empty (equal)
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_rdy  = !full;
    assign rd_vld  = !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_en   = wr_vld && !full;
    assign rd_en   = rd_rdy && !empty;

    // Pointer advance
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/multisim_server_port.sv
// Server-side endpoint of a multisim channel pair.
// Push path: DUT beats are tagged {SERVER_ID, seq} and queued toward transport TX.
// Pull path: transport RX frames matching SERVER_ID are queued toward the DUT;
// others are dropped and counted (saturating).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   push_vld/push_rdy/push_data    DUT push beats
//   tx_vld/tx_rdy/tx_data          outgoing frames {id, seq, payload}
//   rx_vld/rx_rdy/rx_data          incoming frames {id, payload}
//   pull_vld/pull_rdy/pull_data    DUT pull beats
//   drop_cnt                       dropped RX frame count, saturates at 255
// Optional: define MULTISIM_SERVER_STATS_EN to add push_cnt/pull_cnt handshake
// counters (32-bit, wrapping).
module multisim_server_port
    import multisim_server_pkg::*;
#(
    parameter int unsigned     DATA_WIDTH = 64,
    parameter int unsigned     DEPTH      = 4,
    parameter logic [ID_W-1:0] SERVER_ID  = 16'h0001
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_vld,
    output logic                           push_rdy,
    input  logic [DATA_WIDTH-1:0]          push_data,
    output logic                           tx_vld,
    input  logic                           tx_rdy,
    output logic [TX_HDR_W+DATA_WIDTH-1:0] tx_data,
    input  logic                           rx_vld,
    output logic                           rx_rdy,
    input  logic [RX_HDR_W+DATA_WIDTH-1:0] rx_data,
    output logic                           pull_vld,
    input  logic                           pull_rdy,
    output logic [DATA_WIDTH-1:0]          pull_data,
    output logic [DROP_W-1:0]              drop_cnt
`ifdef MULTISIM_SERVER_STATS_EN
    ,
    output logic [31:0]                    push_cnt,
    output logic [31:0]                    pull_cnt
`endif
);

    localparam int unsigned TX_W = TX_HDR_W + DATA_WIDTH;

    logic              rdy_q, rdy_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              push_wr_rdy, pull_wr_rdy;
    logic              push_acc, rx_acc, id_match;
    logic [TX_W-1:0]   push_frame;

    // Readies are held low until one full cycle after reset release
    assign push_rdy   = rdy_q && push_wr_rdy;
    assign rx_rdy     = rdy_q && pull_wr_rdy;
    assign push_acc   = push_vld && push_rdy;
    assign rx_acc     = rx_vld && rx_rdy;
    assign id_match   = (rx_data[RX_HDR_W+DATA_WIDTH-1 -: ID_W] == SERVER_ID);
    assign push_frame = {make_tx_hdr(SERVER_ID, seq_q), push_data};
    assign drop_cnt   = drop_q;

    // Sequence number and saturating drop counter
    always_comb begin
        rdy_d  = 1'b1;
        seq_d  = seq_q;
        drop_d = drop_q;
        if (push_acc) seq_d = seq_q + SEQ_W'(1);
        if (rx_acc && !id_match && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q  <= 1'b0;
            seq_q  <= '0;
            drop_q <= '0;
        end else begin
            rdy_q  <= rdy_d;
            seq_q  <= seq_d;
            drop_q <= drop_d;
        end
    end

    multisim_server_fifo #(
        .WIDTH (TX_W),
        .DEPTH (DEPTH)
    ) u_push_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_vld  (push_acc),
        .wr_rdy  (push_wr_rdy),
        .wr_data (push_frame),
        .rd_vld  (tx_vld),
        .rd_rdy  (tx_rdy),
        .rd_data (tx_data)
    );

    multisim_server_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_pull_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_vld  (rx_acc && id_match),
        .wr_rdy  (pull_wr_rdy),
        .wr_data (rx_data[DATA_WIDTH-1:0]),
        .rd_vld  (pull_vld),
        .rd_rdy  (pull_rdy),
        .rd_data (pull_data)
    );

`ifdef MULTISIM_SERVER_STATS_EN
    logic [31:0] push_cnt_q, push_cnt_d;
    logic [31:0] pull_cnt_q, pull_cnt_d;

    // Completed-handshake counters, wrapping
    always_comb begin
        push_cnt_d = push_cnt_q;
        pull_cnt_d = pull_cnt_q;
        if (push_acc)            push_cnt_d = push_cnt_q + 32'(1);
        if (pull_vld && pull_rdy) pull_cnt_d = pull_cnt_q + 32'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            push_cnt_q <= '0;
            pull_cnt_q <= '0;
        end else begin
            push_cnt_q <= push_cnt_d;
            pull_cnt_q <= pull_cnt_d;
        end
    end

    assign push_cnt = push_cnt_q;
    assign pull_cnt = pull_cnt_q;
`endif

endmodule

// File: tb/tb_multisim_server_port.sv
// Scoreboard bench for multisim_server_port: drivers push expected frames/beats
// into queues, negedge monitors pop and compare on every completed handshake.
module tb_multisim_server_port;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 4;
    localparam logic [15:0] SID   = 16'h0001;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_vld, push_rdy;
    logic [DW-1:0] push_data;
    logic          tx_vld, tx_rdy;
    logic [DW+31:0] tx_data;
    logic          rx_vld, rx_rdy;
    logic [DW+15:0] rx_data;
    logic          pull_vld, pull_rdy;
    logic [DW-1:0] pull_data;
    logic [7:0]    drop_cnt;
`ifdef MULTISIM_SERVER_STATS_EN
    logic [31:0]   push_cnt, pull_cnt;
`endif

    logic [DW+31:0] tx_exp[$];
    logic [DW-1:0]  rx_exp[$];
    logic [15:0]    seq_m;
    logic [7:0]     drop_m;
    int             n_vec = 0;
    int             n_bad = 0;

    always #5 clk = ~clk;

    multisim_server_port #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .SERVER_ID  (SID)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (push_vld),
        .push_rdy  (push_rdy),
        .push_data (push_data),
        .tx_vld    (tx_vld),
        .tx_rdy    (tx_rdy),
        .tx_data   (tx_data),
        .rx_vld    (rx_vld),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .pull_vld  (pull_vld),
        .pull_rdy  (pull_rdy),
        .pull_data (pull_data),
        .drop_cnt  (drop_cnt)
`ifdef MULTISIM_SERVER_STATS_EN
        ,
        .push_cnt  (push_cnt),
        .pull_cnt  (pull_cnt)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [127:0] act);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Monitors: compare on each handshake the DUT will complete at the next edge
    always @(negedge clk) begin
        if (!rst && tx_vld && tx_rdy) begin
            if (tx_exp.size() == 0) fail("tx_unexpected", 128'(tx_data));
            else check("tx_frame", 128'(tx_data), 128'(tx_exp.pop_front()));
        end
        if (!rst && pull_vld && pull_rdy) begin
            if (rx_exp.size() == 0) fail("pull_unexpected", 128'(pull_data));
            else check("pull_data", 128'(pull_data), 128'(rx_exp.pop_front()));
        end
    end

    task automatic push_beat(input logic [DW-1:0] d);
        int guard = 0;
        push_vld  = 1'b1;
        push_data = d;
        forever begin
            @(negedge clk);
            if (push_rdy) begin
                tx_exp.push_back({SID, seq_m, d});
                seq_m = seq_m + 16'd1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            guard++;
            if (guard > 200) begin
                fail("push_timeout", 128'(d));
                break;
            end
        end
        push_vld = 1'b0;
    endtask

    task automatic send_rx(input logic [15:0] id, input logic [DW-1:0] d);
        int guard = 0;
        rx_vld  = 1'b1;
        rx_data = {id, d};
        forever begin
            @(negedge clk);
            if (rx_rdy) begin
                if (id == SID) rx_exp.push_back(d);
                else if (drop_m != 8'hFF) drop_m = drop_m + 8'd1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            guard++;
            if (guard > 200) begin
                fail("rx_timeout", 128'(d));
                break;
            end
        end
        rx_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((tx_exp.size() != 0 || rx_exp.size() != 0) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (tx_exp.size() != 0 || rx_exp.size() != 0)
            fail("drain_timeout", 128'(tx_exp.size() + rx_exp.size()));
        @(posedge clk); #1;
    endtask

    // Reset for n+1 edges, checking idle state during and just after reset
    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst      = 1'b1;
        push_vld = 1'b0;
        rx_vld   = 1'b0;
        tx_exp.delete();
        rx_exp.delete();
        seq_m    = 16'd0;
        drop_m   = 8'd0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        check("rst_push_rdy", 128'(push_rdy), 128'(0));
        check("rst_rx_rdy",   128'(rx_rdy),   128'(0));
        check("rst_tx_vld",   128'(tx_vld),   128'(0));
        check("rst_pull_vld", 128'(pull_vld), 128'(0));
        check("rst_drop_cnt", 128'(drop_cnt), 128'(drop_m));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post1_push_rdy", 128'(push_rdy), 128'(0));
        check("post1_rx_rdy",   128'(rx_rdy),   128'(0));
        @(negedge clk);
        check("post2_push_rdy", 128'(push_rdy), 128'(1));
        check("post2_rx_rdy",   128'(rx_rdy),   128'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        push_vld  = 1'b0;
        push_data = '0;
        rx_vld    = 1'b0;
        rx_data   = '0;
        tx_rdy    = 1'b0;
        pull_rdy  = 1'b0;
        seq_m     = 16'd0;
        drop_m    = 8'd0;

        // Reset then idle
        do_reset(2);

        // Three tagged frames, first one checked for one-cycle latency
        tx_rdy = 1'b1;
        check("tx_idle_vld", 128'(tx_vld), 128'(0));
        push_beat(64'hA);
        check("tx_latency_vld", 128'(tx_vld), 128'(1));
        push_beat(64'hB);
        push_beat(64'hC);
        wait_drain();

        // Backpressure: fill to DEPTH, fifth beat waits for a pop
        do_reset(1);
        tx_rdy = 1'b0;
        for (int i = 0; i < 4; i++) push_beat(64'(32'h100 + i));
        @(negedge clk);
        check("full_push_rdy", 128'(push_rdy), 128'(0));
        check("full_tx_vld",   128'(tx_vld),   128'(1));
        @(posedge clk); #1;
        tx_rdy = 1'b1;
        push_beat(64'h104);
        wait_drain();

        // RX filtering and drop saturation
        pull_rdy = 1'b1;
        send_rx(16'h0001, 64'h11);
        send_rx(16'h0002, 64'h22);
        send_rx(16'h0001, 64'h33);
        wait_drain();
        check("drop_cnt_one", 128'(drop_cnt), 128'(drop_m));
        for (int i = 0; i < 300; i++) send_rx(16'h8000 | 16'(i), 64'(i));
        wait_drain();
        check("drop_cnt_sat", 128'(drop_cnt), 128'(drop_m));

        // Mid-stream reset with two entries in each FIFO
        tx_rdy   = 1'b0;
        pull_rdy = 1'b0;
        push_beat(64'hD0);
        push_beat(64'hD1);
        send_rx(16'h0001, 64'hE0);
        send_rx(16'h0001, 64'hE1);
        @(negedge clk);
        check("pre_rst_tx_vld",   128'(tx_vld),   128'(1));
        check("pre_rst_pull_vld", 128'(pull_vld), 128'(1));
        do_reset(1);
        @(negedge clk);
        check("flushed_tx_vld",   128'(tx_vld),   128'(0));
        check("flushed_pull_vld", 128'(pull_vld), 128'(0));
        @(posedge clk); #1;
        tx_rdy   = 1'b1;
        pull_rdy = 1'b1;
        push_beat(64'hDD);
        send_rx(16'h0001, 64'h44);
        wait_drain();

        // Sequence wrap: 65536 beats, the next one carries seq 0
        do_reset(1);
        tx_rdy = 1'b1;
        for (int i = 0; i < 65536; i++) push_beat(64'(i));
        check("seq_model_wrapped", 128'(seq_m), 128'(0));
        push_beat(64'hFEED);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/multisim_server_port.md
Name: multisim_server_port

Overview:
- Synthesizable server-side endpoint of a multisim channel pair.
- Push path: the DUT pushes beats in over valid/ready. Each beat is buffered, tagged with this server's ID and a sequence number, and sent as a frame on the transport TX interface.
- Pull path: frames arrive on the transport RX interface. Frames whose ID matches this server are buffered and presented to the DUT over valid/ready; all other frames are dropped.
- Sits between DUT-facing channel logic and the inter-simulation transport.

Parameters:
- DATA_WIDTH, 64, payload width in bits (≥1).
- DEPTH, 4, entries per FIFO; power of two, ≥2.
- SERVER_ID, 16'h0001, 16-bit ID placed in TX frames and matched on RX frames.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- push_vld  in  1  DUT push beat valid
- push_rdy  out  1  push beat accepted when push_vld&push_rdy
- push_data  in  DATA_WIDTH  push payload
- tx_vld  out  1  transport frame valid
- tx_rdy  in  1  transport accepts frame
- tx_data  out  32+DATA_WIDTH  frame = {id[15:0], seq[15:0], payload}
- rx_vld  in  1  incoming frame valid
- rx_rdy  out  1  incoming frame accepted
- rx_data  in  16+DATA_WIDTH  frame = {id[15:0], payload}
- pull_vld  out  1  DUT pull beat valid
- pull_rdy  in  1  DUT consumes beat
- pull_data  out  DATA_WIDTH  pull payload
- drop_cnt  out  8  count of dropped RX frames, saturating

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high. All state updates on the rising edge of clk.
- While rst=1 and on the first cycle after it deasserts:
  - push_rdy=0, rx_rdy=0, tx_vld=0, pull_vld=0.
  - seq=0, drop_cnt=0, both FIFOs empty.
  - Ready outputs go high starting from the second cycle after rst deasserts (ready-after-reset register).
- Push FIFO:
  - push_rdy = !push_full (and post-reset ready).
  - Accept when push_vld&push_rdy: write {SERVER_ID, seq, push_data}, then seq <= seq+1, wrapping 16'hFFFF→16'h0000.
  - tx_vld = !push_empty; tx_data = FIFO head.
  - Pop when tx_vld&tx_rdy.
- Pull FIFO:
  - rx_rdy = !pull_full (and post-reset ready).
  - On rx_vld&rx_rdy: if rx_data id == SERVER_ID, write the payload; otherwise discard the frame and increment drop_cnt, saturating at 255.
  - pull_vld = !pull_empty; pull_data = head; pop on pull_vld&pull_rdy.
- Latency: a beat accepted at edge N is visible at the FIFO output after edge N (no combinational bypass; an empty FIFO never presents same-cycle input).
- Full FIFO: ready=0, even if a pop occurs in the same cycle (no write-through-on-pop).
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur and the count is unchanged.
- Output stability: valid and data hold stable until the handshake completes; valid never drops without a handshake except on reset.
- Pointers: log2(DEPTH)+1 bits, so full and empty are distinguished by the MSB.
- Reset mid-operation flushes both FIFOs and discards in-flight frames; seq returns to 0.

Optional Feature:
- MULTISIM_SERVER_STATS_EN defined: adds outputs push_cnt[31:0] and pull_cnt[31:0].
  - Each counts completed handshakes: push side on push_vld&push_rdy, pull side on pull_vld&pull_rdy.
  - Both wrap at 2^32 and clear on rst.
- Macro undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package multisim_server_pkg:
  - ID_W=16, SEQ_W=16, DROP_W=8.
  - Parameterized frame layout helpers: tx frame {id, seq, payload}, rx frame {id, payload}.
- Sub-module multisim_server_fifo (WIDTH, DEPTH; wr_vld/wr_rdy, rd_vld/rd_rdy, registered-pointer RAM FIFO), instantiated once for push and once for pull.

Test Plan:
- Reset then idle: rst=1 for 3 cycles → all valids 0, ready 0 through the first post-reset cycle, then push_rdy=1 and rx_rdy=1; drop_cnt=0.
- Push 3 beats 0xA, 0xB, 0xC with tx_rdy=1 → tx_data {0x0001,0x0000,0xA}, {0x0001,0x0001,0xB}, {0x0001,0x0002,0xC}; each frame appears one cycle after its accept.
- Backpressure: tx_rdy=0, push 5 beats (DEPTH=4) → push_rdy=0 after 4 accepts; asserting tx_rdy drains frames in order with seq 0..3, then the 5th beat is accepted with seq 4.
- Seq wrap: preload by pushing 65536 beats, then push one more → that frame carries seq 0x0000.
- RX filtering: frames {0x0001,0x11}, {0x0002,0x22}, {0x0001,0x33} → pull_data 0x11 then 0x33; drop_cnt=1; 300 mismatched frames → drop_cnt=255.
- Mid-stream reset with both FIFOs holding 2 entries → after reset tx_vld=0, pull_vld=0, the next push frame carries seq 0.
